ws2812b_frame: RTL and testbench

WS2812B_FRAME -- requirements
Module: ws2812b_frame

---
 rtl/ws2812b_frame.sv | 134 +++++++++++++
 tb/tb_ws2812b_frame.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_frame.sv
// Purpose: streams LED_NUM 24-bit GRB pixels MSB-first to a bit encoder, then holds the line idle for the latch time.
// Latency: accepted pixel reaches bit_en two edges later; a one-word holding register keeps bits back-to-back.
// Backpressure: pix_ready drops while the holding word is occupied; bit_busy stalls shifting. WS2812B_RGB_SWAP_EN takes RGB input.
module ws2812b_frame #(
    parameter int LED_NUM      = 64,
    parameter int IDX_W        = 8,
    parameter int RESET_CYCLES = 8100
) (
    input  logic             Clock_27mhz,
    input  logic             rst,
    input  logic             start,
    input  logic [23:0]      pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [IDX_W-1:0] pix_idx,
    output logic             bit_out,
    output logic             bit_en,
    input  logic             bit_busy,
    output logic             frame_busy,
    output logic             frame_done,
    output logic             underrun
);
    localparam int CNT_W = $clog2(LED_NUM + 1);
    localparam int LAT_W = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] LED_LAST = CNT_W'(LED_NUM);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DRAIN, LATCH} state_t;

    state_t           state;
    logic [23:0]      shift_reg;
    logic [23:0]      hold_reg;
    logic             hold_full;
    logic [4:0]       bit_cnt;
    logic [CNT_W-1:0] acc_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic [23:0]      pix_grb;
    logic             xfer;
    logic             consume;
    logic             last_bit;

`ifdef WS2812B_RGB_SWAP_EN
    assign pix_grb = {pix_data[15:8], pix_data[23:16], pix_data[7:0]};
`else
    assign pix_grb = pix_data;
`endif

    assign pix_ready = (state == FETCH || state == SHIFT) && !hold_full && (acc_cnt < LED_LAST);
    assign xfer      = pix_valid && pix_ready;
    assign consume   = bit_en && !bit_busy;
    assign last_bit  = (bit_cnt == 5'd23);
    assign bit_out   = bit_en & shift_reg[23];

    always_ff @(posedge Clock_27mhz) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            hold_reg   <= '0;
            hold_full  <= 1'b0;
            bit_cnt    <= '0;
            acc_cnt    <= '0;
            lat_cnt    <= '0;
            pix_idx    <= '0;
            bit_en     <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (xfer) begin
                hold_reg  <= pix_grb;
                hold_full <= 1'b1;
                acc_cnt   <= acc_cnt + 1'b1;
                pix_idx   <= pix_idx + IDX_W'(1);
            end
            case (state)
                IDLE: begin
                    // frame_done marks the IDLE cycle that closes a frame; a start there is dropped
                    if (start && !frame_done) begin
                        pix_idx    <= '0;
                        acc_cnt    <= '0;
                        underrun   <= 1'b0;
                        hold_full  <= 1'b0;
                        bit_en     <= 1'b0;
                        frame_busy <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH, SHIFT: begin
                    if (!bit_en) begin
                        if (hold_full) begin
                            shift_reg <= hold_reg;
                            hold_full <= 1'b0;
                            bit_cnt   <= '0;
                            bit_en    <= 1'b1;
                            state     <= SHIFT;
                        end
                    end else if (consume) begin
                        if (!last_bit) begin
                            shift_reg <= {shift_reg[22:0], 1'b0};
                            bit_cnt   <= bit_cnt + 5'd1;
                        end else if (hold_full) begin
                            shift_reg <= hold_reg;
                            hold_full <= 1'b0;
                            bit_cnt   <= '0;
                        end else if (acc_cnt == LED_LAST) begin
                            bit_en <= 1'b0;
                            state  <= DRAIN;
                        end else begin
                            bit_en   <= 1'b0;
                            underrun <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!bit_busy) begin
                        lat_cnt <= '0;
                        state   <= LATCH;
                    end
                end
                LATCH: begin
                    if (lat_cnt == LAT_LAST) begin
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812b_frame.sv
// Purpose: self-checking bench for ws2812b_frame (LED_NUM=2, short latch) with a busy-holding encoder model.
// Latency: compares bit streams, latch length and handshake indices against a pixel-level reference model.
// Backpressure: encoder model holds bit_busy for a per-frame number of cycles after every consumed bit.
module tb_ws2812b_frame;
    localparam int LED_NUM = 2;
    localparam int IDX_W   = 8;
    localparam int RC      = 40;

    logic             Clock_27mhz = 1'b0;
    logic             rst;
    logic             start;
    logic [23:0]      pix_data;
    logic             pix_valid;
    logic             pix_ready;
    logic [IDX_W-1:0] pix_idx;
    logic             bit_out;
    logic             bit_en;
    logic             bit_busy;
    logic             frame_busy;
    logic             frame_done;
    logic             underrun;

    ws2812b_frame #(.LED_NUM(LED_NUM), .IDX_W(IDX_W), .RESET_CYCLES(RC)) dut (
        .Clock_27mhz(Clock_27mhz),
        .rst        (rst),
        .start      (start),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_idx    (pix_idx),
        .bit_out    (bit_out),
        .bit_en     (bit_en),
        .bit_busy   (bit_busy),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    always #5 Clock_27mhz = ~Clock_27mhz;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge Clock_27mhz) cyc <= cyc + 1;

    int   busy_len = 0;
    bit   stab_on  = 1'b0;
    int   stab_err = 0;
    int   first_c  = 0;
    int   last_c   = 0;
    logic bits_q[$];

    typedef struct {
        logic [23:0] p0;
        logic [23:0] p1;
        int          busy;
        int          vpct;
        int          hold_len;
        bit          start_mid;
        bit          exp_und;
        bit          exp_nogap;
    } row_t;
    row_t rows [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock_27mhz);
        #1;
    endtask

    function automatic logic [23:0] to_grb(input logic [23:0] w);
`ifdef WS2812B_RGB_SWAP_EN
        return {w[15:8], w[23:16], w[7:0]};
`else
        return w;
`endif
    endfunction

    // Encoder model: a consume happens on the edge after a negedge that sees bit_en && !bit_busy
    initial begin
        bit_busy = 1'b0;
        forever begin
            @(negedge Clock_27mhz);
            if (!rst && bit_en && !bit_busy) begin
                logic ref_en;
                logic ref_out;
                ref_en  = 1'b0;
                ref_out = 1'b0;
                if (bits_q.size() == 0) first_c = cyc + 1;
                last_c = cyc + 1;
                bits_q.push_back(bit_out);
                if (busy_len > 0) begin
                    @(posedge Clock_27mhz);
                    #1 bit_busy = 1'b1;
                    for (int i = 0; i < busy_len; i++) begin
                        @(negedge Clock_27mhz);
                        if (i == 0) begin
                            ref_en  = bit_en;
                            ref_out = bit_out;
                        end else if (stab_on && (bit_en !== ref_en || bit_out !== ref_out)) begin
                            stab_err++;
                        end
                    end
                    @(posedge Clock_27mhz);
                    #1 bit_busy = 1'b0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_ready"}, pix_ready, 0);
        check({tag, "_pix_idx"}, pix_idx, 0);
        check({tag, "_bit_out"}, bit_out, 0);
        check({tag, "_bit_en"}, bit_en, 0);
        check({tag, "_frame_busy"}, frame_busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_underrun"}, underrun, 0);
    endtask

    task automatic feed_pixel(input int k, input logic [23:0] w, input int vpct);
        int t;
        while (int'($urandom_range(99)) >= vpct) tick;
        pix_data  = w;
        pix_valid = 1'b1;
        t = 0;
        while (!pix_ready && t < 5000) begin
            tick;
            t++;
        end
        tick;
        pix_valid = 1'b0;
        check("pix_idx_after_accept", pix_idx, k + 1);
    endtask

    task automatic run_frame(input logic [23:0] p0, input logic [23:0] p1, input int busy,
                             input int vpct, input int hold_len, input bit start_mid,
                             output bit und, output bit nogap);
        logic [23:0] px [2];
        logic [23:0] w;
        logic        exp_bits[$];
        int          t;
        int          nerr;
        px[0]    = p0;
        px[1]    = p1;
        busy_len = busy;
        stab_err = 0;
        bits_q.delete();
        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_frame_busy", frame_busy, 1);
        check("start_underrun_clear", underrun, 0);
        check("start_pix_idx", pix_idx, 0);
        for (int k = 0; k < LED_NUM; k++) begin
            if (k == 1) begin
                for (int i = 0; i < hold_len; i++) begin
                    if (start_mid && i == 2) begin
                        check("start_mid_in_shift", bit_en, 1);
                        start = 1'b1;
                    end
                    tick;
                    start = 1'b0;
                end
            end
            feed_pixel(k, px[k], vpct);
        end
        t = 0;
        while (frame_done !== 1'b1 && t < 20000) begin
            tick;
            t++;
        end
        check("frame_done_seen", frame_done, 1);
        check("latch_len", cyc - last_c, busy + 1 + RC);
        check("done_frame_busy", frame_busy, 0);
        check("pix_idx_stops", pix_idx, LED_NUM);
        und   = underrun;
        nogap = ((last_c - first_c) == 47 * (busy + 1));
        for (int k = 0; k < LED_NUM; k++) begin
            w = to_grb(px[k]);
            for (int b = 23; b >= 0; b--) exp_bits.push_back(w[b]);
        end
        check("bit_count", bits_q.size(), exp_bits.size());
        nerr = 0;
        for (int i = 0; i < bits_q.size() && i < exp_bits.size(); i++)
            if (bits_q[i] !== exp_bits[i]) nerr++;
        check("bit_stream_errs", nerr, 0);
        if (busy > 0 && stab_on) check("stable_between_consumes", stab_err, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("done_one_cycle", frame_done, 0);
        check("start_at_done_ignored", frame_busy, 0);
        check("idle_pix_ready", pix_ready, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit   und;
        bit   nogap;
        int   t;
        int   ndone;
        logic [23:0] got;
        rst       = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        rows[0] = '{24'hA50F81, 24'h00FF00, 0,  100, 0,   1'b0, 1'b0, 1'b1};
        rows[1] = '{24'hA50F81, 24'h00FF00, 30, 100, 0,   1'b0, 1'b0, 1'b1};
        rows[2] = '{24'hA50F81, 24'h00FF00, 0,  100, 100, 1'b0, 1'b1, 1'b0};
        rows[3] = '{24'hA50F81, 24'h00FF00, 0,  100, 3,   1'b1, 1'b0, 1'b1};
        rows[4] = '{24'h5A5A5A, 24'hC3C3C3, 2,  100, 3,   1'b0, 1'b0, 1'b1};
        repeat (3) tick;
        check_reset_outputs("init");
        rst = 1'b0;

        for (int r = 0; r < 5; r++) begin
            stab_on = !rows[r].exp_und;
            run_frame(rows[r].p0, rows[r].p1, rows[r].busy, rows[r].vpct, rows[r].hold_len,
                      rows[r].start_mid, und, nogap);
            check($sformatf("row%0d_underrun", r), und, rows[r].exp_und);
            check($sformatf("row%0d_nogap", r), nogap, rows[r].exp_nogap);
        end

        for (int f = 0; f < 6; f++) begin
            stab_on = 1'b0;
            run_frame(24'($urandom), 24'($urandom), int'($urandom_range(3, 0)),
                      int'($urandom_range(100, 30)), 0, 1'b0, und, nogap);
        end

        // reset while a bit is being held by the encoder
        stab_on  = 1'b0;
        busy_len = 5;
        bits_q.delete();
        start = 1'b1;
        tick;
        start = 1'b0;
        feed_pixel(0, 24'hFFFFFF, 100);
        repeat (10) tick;
        check("pre_rst_mid_bit_en", bit_en, 1);
        rst = 1'b1;
        tick;
        check_reset_outputs("rst_mid_bit");
        rst = 1'b0;
        repeat (10) tick;

        // reset while waiting on a late pixel
        busy_len = 0;
        bits_q.delete();
        start = 1'b1;
        tick;
        start = 1'b0;
        feed_pixel(0, 24'hFFFFFF, 100);
        repeat (40) tick;
        check("underrun_set", underrun, 1);
        check("underrun_bit_en_low", bit_en, 0);
        rst = 1'b1;
        tick;
        check_reset_outputs("rst_underrun");
        rst = 1'b0;
        tick;

        // reset in the middle of the latch interval
        bits_q.delete();
        start = 1'b1;
        tick;
        start = 1'b0;
        feed_pixel(0, 24'hA50F81, 100);
        feed_pixel(1, 24'h00FF00, 100);
        t = 0;
        while (bits_q.size() < 48 && t < 2000) begin
            tick;
            t++;
        end
        repeat (RC / 2) tick;
        check("pre_rst_latch_busy", frame_busy, 1);
        check("pre_rst_latch_bit_en", bit_en, 0);
        rst = 1'b1;
        tick;
        check_reset_outputs("rst_latch");
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 2 * RC; i++) begin
            tick;
            if (frame_done) ndone++;
        end
        check("no_done_after_rst", ndone, 0);

        // start on the very first cycle after reset releases
        rst = 1'b1;
        tick;
        rst = 1'b0;
        stab_on = 1'b1;
        run_frame(24'h123456, 24'h789ABC, 1, 100, 0, 1'b0, und, nogap);
        check("post_rst_frame_underrun", und, 0);

`ifdef WS2812B_RGB_SWAP_EN
        run_frame(24'h112233, 24'h445566, 0, 100, 0, 1'b0, und, nogap);
        got = '0;
        for (int i = 0; i < 24 && i < bits_q.size(); i++) got = {got[22:0], bits_q[i]};
        check("rgb_swap_first_word", got, 24'h221133);
`else
        got = '0;
        for (int i = 0; i < 24 && i < bits_q.size(); i++) got = {got[22:0], bits_q[i]};
        check("grb_first_word", got, 24'h123456);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
